grf_multiport: RTL and testbench
================================

# grf_multiport

Parametrised general-purpose register file for the pipelined CPU, replacing the single-write, two-read GRF. It adds a configurable number of read ports, two write ports with fixed priority, same-cycle write-to-read bypass and a per-register pending scoreboard. Decode uses the scoreboard to stall on outstanding producers. It sits between the ID stage (reads, issue) and the WB stage (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads 0, is never written and never pending
---
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; clears every register and every pending bit
- wen0 / waddr0 / wdata0 / wpc0  in  1 / ADDR_W / DATA_W / 32  write port 0 (lower priority); wpc0 is the instruction address, trace only
- wen1 / waddr1 / wdata1 / wpc1  in  1 / ADDR_W / DATA_W / 32  write port 1 (higher priority)
- raddr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, combinational, port k uses [k*DATA_W +: DATA_W]
- rbusy  out  NUM_RD  port k's register has an outstanding producer
- issue_en / issue_addr  in  1 / ADDR_W  mark a destination register pending

## Operation
- Write: on the edge, if wenX and waddrX is not 0 (or ZERO_REG=0), regs[waddrX] <= wdataX. If both ports target the same address, port 1's data is stored.
- Read: rdata[k] = bypass value, else regs[raddr[k]]. Bypass applies when a write enable is high, its address matches raddr[k], that address is not a suppressed zero register, and reset is low. Port 1 takes priority over port 0. Register 0 with ZERO_REG=1 always reads 0.
- Scoreboard, per register:
  - pending is set on issue_en.
  - pending is cleared when either write port writes that address.
  - If issue and clear hit the same address in the same cycle, set wins, because a new producer supersedes the old one.
  - issue_addr 0 is ignored when ZERO_REG=1.
- rbusy[k] = pending[raddr[k]] AND NOT (a write to raddr[k] this cycle). The bypass already supplies that value, so the port is not busy. rbusy for register 0 is 0.
- Reset:
  - Clears all registers and pending bits on the edge.
  - While reset is high, writes and issues are ignored and bypass is disabled.
  - rdata shows the array contents; after the reset edge that is 0.
  - rbusy reads 0 after the reset edge.
- Reset during outstanding pendings discards them; a late write after reset still writes normally.

## Timing
- Reset values after the reset edge: all rdata = 0, rbusy = 0.
- Write latency: 0 cycles to the same-cycle read through the bypass, 1 edge into the array.
- Pending is visible on rbusy the cycle after issue_en.
- A clear through a write lowers rbusy combinationally in the write cycle. The bit is cleared at the edge.
- No handshakes. All inputs are sampled on the rising edge of clk.

## Configuration
- GRF_TRACE_EN defined: every committed write prints the line "<time>@<wpcX>: $<addr> <= <data>" in the $time/%d/%h format.
  - Port 0 prints before port 1.
  - When both ports hit the same address, only port 1 prints.
- GRF_TRACE_EN undefined: no display statements; wpc0 and wpc1 are unused. This is the synthesis build.

## Structure
- Package grf_pkg holds:
  - the default constants GRF_DATA_W=32, GRF_ADDR_W=5, GRF_NUM_RD=2
  - the helper function for one-hot address decode
- Sub-module grf_scoreboard (parameter ADDR_W, ZERO_REG):
  - inputs: issue, the two write-clears and NUM_RD read addresses
  - output: the pending vector and rbusy
- The register array, bypass muxes and trace stay in grf_multiport.

## Test plan
- Reset, then read all 32 addresses on every port -> every read is 0, rbusy = 0.
- wen0 writes $5 = 0x12345678 with raddr port0 = 5 in the same cycle -> rdata0 = 0x12345678 in that cycle and in the next cycle.
- Both ports write $7 in one cycle (port 0 writes 0xAAAA0000, port 1 writes 0x0000BBBB) -> bypass and the stored value are both 0x0000BBBB; with GRF_TRACE_EN exactly one trace line is printed.
- Write 0xFFFFFFFF to $0 and issue $0 -> reading $0 gives 0, rbusy = 0, no trace line.
- issue $3, wait 2 cycles -> rbusy = 1 on a port reading 3. Then wen1 writes $3 = 0x42 -> that cycle rbusy = 0 and rdata = 0x42. The next cycle pending is clear.
- In the same cycle, issue $9 and wen0 writes $9 = 1 -> the next cycle rbusy = 1 and the stored value = 1. Assert reset -> the next cycle rbusy = 0 and $9 reads 0.

Source files
------------

// File: rtl/grf_pkg.sv
// grf_pkg: shared constants and helpers for the multiport register file.
//   GRF_DATA_W / GRF_ADDR_W / GRF_NUM_RD : default widths and read-port count
//   GRF_MAX_ADDR_W                       : widest address the decode helper covers
//   grf_onehot()                         : enable-gated one-hot address decode
package grf_pkg;

  localparam int unsigned GRF_DATA_W     = 32;
  localparam int unsigned GRF_ADDR_W     = 5;
  localparam int unsigned GRF_NUM_RD     = 2;
  localparam int unsigned GRF_MAX_ADDR_W = 8;
  localparam int unsigned GRF_MAX_DEPTH  = 1 << GRF_MAX_ADDR_W;

  // One-hot decode of addr, all zeros when en is low; callers truncate to their depth.
  function automatic logic [GRF_MAX_DEPTH-1:0] grf_onehot(
    input logic [GRF_MAX_ADDR_W-1:0] addr,
    input logic                      en
  );
    logic [GRF_MAX_DEPTH-1:0] v;
    v = '0;
    if (en) v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register pending bits tracking outstanding producers.
//   clk, reset            : clock, synchronous active-high reset (clears all pending)
//   issue_en / issue_addr : mark a destination register pending
//   clr0_* / clr1_*       : committed writes (already qualified by the caller)
//   raddr                 : NUM_RD packed read addresses
//   pending               : pending vector (registered state)
//   rbusy                 : per read port, pending and not being written this cycle
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int unsigned ADDR_W   = GRF_ADDR_W,
  parameter int unsigned NUM_RD   = GRF_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     clr0_en,
  input  logic [ADDR_W-1:0]        clr0_addr,
  input  logic                     clr1_en,
  input  logic [ADDR_W-1:0]        clr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic              issue_q;
  logic              clr0_q;
  logic              clr1_q;
  logic [DEPTH-1:0]  set_v;
  logic [DEPTH-1:0]  clr_v;
  logic [DEPTH-1:0]  pending_nxt;
  logic [ADDR_W-1:0] ra;

  // Qualify issue/clear; issue to a hardwired zero register is dropped.
  always_comb begin
    issue_q = issue_en & ~reset & ~((ZERO_REG != 0) && (issue_addr == '0));
    clr0_q  = clr0_en & ~reset;
    clr1_q  = clr1_en & ~reset;
    set_v   = DEPTH'(grf_onehot(GRF_MAX_ADDR_W'(issue_addr), issue_q));
    clr_v   = DEPTH'(grf_onehot(GRF_MAX_ADDR_W'(clr0_addr), clr0_q))
            | DEPTH'(grf_onehot(GRF_MAX_ADDR_W'(clr1_addr), clr1_q));
    // Set applied after clear: a new producer supersedes the retiring one.
    pending_nxt = (pending & ~clr_v) | set_v;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  // A same-cycle write is forwarded by the bypass, so the port is not busy.
  always_comb begin
    rbusy = '0;
    ra    = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      rbusy[k] = pending[ra]
               & ~(clr0_q && (clr0_addr == ra))
               & ~(clr1_q && (clr1_addr == ra))
               & ~((ZERO_REG != 0) && (ra == '0));
    end
  end

endmodule

// File: rtl/grf_multiport.sv
// grf_multiport: general-purpose register file with NUM_RD combinational read
// ports, two prioritised write ports, write-to-read bypass and a pending scoreboard.
//   clk, reset                 : clock, synchronous active-high reset
//   wen0/waddr0/wdata0/wpc0    : write port 0 (lower priority), wpc0 trace only
//   wen1/waddr1/wdata1/wpc1    : write port 1 (higher priority), wpc1 trace only
//   raddr / rdata / rbusy      : packed read addresses, read data, busy flags
//   issue_en / issue_addr      : mark destination register pending
// Build option: GRF_TRACE_EN prints one line per committed write.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W   = GRF_DATA_W,
  parameter int unsigned ADDR_W   = GRF_ADDR_W,
  parameter int unsigned NUM_RD   = GRF_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [31:0]              wpc0,
  input  logic                     wen1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [31:0]              wpc1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;
  logic [DEPTH-1:0]  pending;

  // Committed write enables: gated by reset and the hardwired zero register.
  assign we0 = wen0 & ~reset & ~((ZERO_REG != 0) && (waddr0 == '0));
  assign we1 = wen1 & ~reset & ~((ZERO_REG != 0) && (waddr1 == '0));

  // Array update; port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else begin
      if (we0) regs[waddr0] <= wdata0;
      if (we1) regs[waddr1] <= wdata1;
    end
  end

  // Read muxes with bypass, port 1 checked last so it has priority.
  always_comb begin
    rdata = '0;
    ra    = '0;
    rv    = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      rv = regs[ra];
      if (we0 && (waddr0 == ra)) rv = wdata0;
      if (we1 && (waddr1 == ra)) rv = wdata1;
      if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
      rdata[k*DATA_W +: DATA_W] = rv;
    end
  end

  grf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .clr0_en    (we0),
    .clr0_addr  (waddr0),
    .clr1_en    (we1),
    .clr1_addr  (waddr1),
    .raddr      (raddr),
    .pending    (pending),
    .rbusy      (rbusy)
  );

  // The pending vector is observational here; decode consumes rbusy.
  logic unused_pending;
  assign unused_pending = ^pending;

`ifdef GRF_TRACE_EN
  // Port 0 prints first; a port-0 write shadowed by port 1 is not reported.
  always_ff @(posedge clk) begin
    if (we0 && !(we1 && (waddr1 == waddr0)))
      $display("%d@%h: $%d <= %h", $time, wpc0, waddr0, wdata0);
    if (we1)
      $display("%d@%h: $%d <= %h", $time, wpc1, waddr1, wdata1);
  end
`else
  logic unused_wpc;
  assign unused_wpc = ^{wpc0, wpc1};
`endif

endmodule

// File: tb/tb_grf_multiport.sv
// Randomised and directed bench for grf_multiport against an array-based model.
module tb_grf_multiport;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             wen0, wen1, issue_en;
  logic [AW-1:0]    waddr0, waddr1, issue_addr;
  logic [DW-1:0]    wdata0, wdata1;
  logic [31:0]      wpc0, wpc1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;

  always #5 clk = ~clk;

  grf_multiport dut (
    .clk        (clk),
    .reset      (reset),
    .wen0       (wen0),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .wpc0       (wpc0),
    .wen1       (wen1),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .wpc1       (wpc1),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .issue_en   (issue_en),
    .issue_addr (issue_addr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] m_regs [DEPTH];
  bit            m_pend [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural view: what a reader of register a sees this cycle.
  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'h0;
    if (!reset && wen1 && int'(waddr1) == a) return wdata1;
    if (!reset && wen0 && int'(waddr0) == a) return wdata0;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input int a);
    bit written;
    written = !reset && ((wen0 && int'(waddr0) == a) || (wen1 && int'(waddr1) == a));
    return (a != 0 && m_pend[a] && !written) ? 32'h1 : 32'h0;
  endfunction

  task automatic check_outputs();
    int a;
    for (int k = 0; k < int'(NR); k++) begin
      a = int'(raddr[k*AW +: AW]);
      check($sformatf("rdata%0d@%0d", k, a), rdata[k*DW +: DW], exp_rd(a));
      check($sformatf("rbusy%0d@%0d", k, a), 32'(rbusy[k]), exp_busy(a));
    end
  endtask

  // Model update for one clock edge with the inputs currently applied.
  task automatic model_commit();
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wen0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
      if (wen1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
      if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wen0 = 1'b0; wen1 = 1'b0; issue_en = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; issue_addr = '0;
    wpc0 = 32'h0000_3000; wpc1 = 32'h0000_3004;
  endtask

  task automatic set_rd(input int k, input int a);
    raddr[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin m_regs[i] = 'x; m_pend[i] = 1'b0; end
    idle();
    raddr = '0;
    reset = 1'b1;
    @(posedge clk); model_commit(); #1;
    tick();
    reset = 1'b0;

    // All addresses read 0 and not busy after reset.
    for (int a = 0; a < int'(DEPTH); a++) begin
      set_rd(0, a); set_rd(1, int'(DEPTH) - 1 - a);
      #1;
      check("rst_rd0", rdata[0 +: DW], 32'h0);
      check("rst_rd1", rdata[DW +: DW], 32'h0);
      check("rst_busy", 32'(rbusy), 32'h0);
    end

    // Same-cycle bypass then stored value.
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678; set_rd(0, 5); set_rd(1, 5);
    #1 check("byp5", rdata[0 +: DW], 32'h1234_5678);
    tick(); idle();
    #1 check("store5", rdata[0 +: DW], 32'h1234_5678);

    // Dual write to the same address: port 1 wins.
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA_0000;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h0000_BBBB; set_rd(0, 7); set_rd(1, 7);
    #1 check("byp7", rdata[DW +: DW], 32'h0000_BBBB);
    tick(); idle();
    #1 check("store7", rdata[0 +: DW], 32'h0000_BBBB);

    // Register 0 is hardwired.
    wen0 = 1'b1; waddr0 = '0; wdata0 = 32'hFFFF_FFFF; issue_en = 1'b1; issue_addr = '0;
    set_rd(0, 0);
    #1 check("zero_byp", rdata[0 +: DW], 32'h0);
    tick(); idle();
    #1 check("zero_rd", rdata[0 +: DW], 32'h0);
    check("zero_busy", 32'(rbusy[0]), 32'h0);

    // Issue, busy, clear by write, busy drops combinationally.
    issue_en = 1'b1; issue_addr = 5'd3; set_rd(1, 3);
    tick(); idle(); tick();
    #1 check("busy3", 32'(rbusy[1]), 32'h1);
    wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h42;
    #1 check("busy3_clr", 32'(rbusy[1]), 32'h0);
    check("byp3", rdata[DW +: DW], 32'h42);
    tick(); idle();
    #1 check("busy3_after", 32'(rbusy[1]), 32'h0);

    // Set wins over clear on the same address, then reset discards it.
    issue_en = 1'b1; issue_addr = 5'd9; wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1;
    set_rd(0, 9);
    tick(); idle();
    #1 check("busy9", 32'(rbusy[0]), 32'h1);
    check("store9", rdata[0 +: DW], 32'h1);
    reset = 1'b1;
    tick(); idle();
    #1 check("busy9_rst", 32'(rbusy[0]), 32'h0);
    check("rd9_rst", rdata[0 +: DW], 32'h0);

    // Randomised traffic with a narrow address pool to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      wen0       = 1'($urandom);
      wen1       = 1'($urandom);
      issue_en   = 1'($urandom);
      waddr0     = AW'(($urandom % 2) ? $urandom_range(0, 5) : $urandom);
      waddr1     = AW'(($urandom % 2) ? $urandom_range(0, 5) : $urandom);
      issue_addr = AW'(($urandom % 2) ? $urandom_range(0, 5) : $urandom);
      wdata0     = $urandom;
      wdata1     = $urandom;
      for (int k = 0; k < int'(NR); k++)
        set_rd(k, ($urandom % 2) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 31)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
